// File: rtl/apb_pkg.sv
// Shared types and default parameter values for the APB4 memory slave.
// Default constants are used as the top-level parameter defaults.
package apb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_DATA_WIDTH  = 32;
  localparam int unsigned DEF_MEM_DEPTH   = 1024;
  localparam int unsigned DEF_WAIT_STATES = 0;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb4_state_t;

endpackage

// File: rtl/apb4_mem_array.sv
// Word-organised storage with a registered read port and per-byte write enables.
// Contents are deliberately not reset.
module apb4_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  localparam int NBYTES    = DATA_WIDTH / 8,
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rd_en_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic [NBYTES-1:0]     wr_be_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (wr_be_i[b]) begin
        mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_idx_i];
    end
  end

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 slave fronting a byte-strobed memory, with a fixed number of wait states
// per access and an error response for misaligned or out-of-range addresses.
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  apb4_state_t           state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      wordIdx_q;
  logic [IDX_W-1:0]      wordIdx_d;
  logic                  err_q;
  logic                  err_d;
  logic                  rdValid_q;
  logic [ADDR_WIDTH-1:0] wordAddr;
  logic [ADDR_WIDTH-1:0] offMask;
  logic                  rdEn;
  logic [NBYTES-1:0]     wrBe;
  logic [DATA_WIDTH-1:0] rdData;

  // The full word address takes part in the range check so that high address
  // bits beyond the index width still raise an error.
  assign wordAddr  = PADDR >> OFF_W;
  assign offMask   = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  assign err_d     = (64'(wordAddr) >= 64'(MEM_DEPTH)) || ((PADDR & offMask) != '0);
  assign wordIdx_d = wordAddr[IDX_W-1:0];

  assign rdEn    = (state_q == IDLE) && PSEL && !PENABLE && !PWRITE && !err_d;
  assign PREADY  = (state_q == ACCESS) && (cnt_q == '0);
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = rdValid_q ? rdData : '0;
  assign wrBe    = (PREADY && PSEL && PENABLE && PWRITE && !err_q) ? PSTRB : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wordIdx_q <= '0;
      err_q     <= 1'b0;
      rdValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            state_q   <= ACCESS;
            cnt_q     <= CNT_W'(WAIT_STATES);
            wordIdx_q <= wordIdx_d;
            err_q     <= err_d;
            rdValid_q <= !PWRITE && !err_d;
          end
        end
        ACCESS: begin
          // Dropping PSEL mid-access abandons the transfer without a write.
          if (!PSEL) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  apb4_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk_i    (PCLK),
    .rd_en_i  (rdEn),
    .rd_idx_i (wordIdx_d),
    .rd_data_o(rdData),
    .wr_be_i  (wrBe),
    .wr_idx_i (wordIdx_q),
    .wr_data_i(PWDATA)
  );

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Scoreboard bench for apb4_mem_slave: one instance with no wait states and one
// with three, both checked against a byte-addressed reference memory.
module tb_apb4_mem_slave;

  localparam int WS0 = 0;
  localparam int WS1 = 3;

  typedef struct {
    int          dut;
    bit          isRead;
    bit          err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  exp_t        sbq[$];
  logic [7:0]  refMem [2][4096];
  int          waitCnt [2];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  apb4_mem_slave #(.WAIT_STATES(WS0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb4_mem_slave #(.WAIT_STATES(WS1)) dut1 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Expected responses come from the byte-level model; the DUT latency expected
  // is simply the configured wait-state count of the instance addressed.
  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb, input bit abort);
    exp_t e;
    bit   err;
    int   base;
    err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd1024);
    if (!abort) begin
      e.dut    = d;
      e.isRead = !wr;
      e.err    = err;
      e.waits  = (d == 0) ? WS0 : WS1;
      e.data   = '0;
      if (!err) begin
        base = int'(addr);
        for (int i = 0; i < 4; i++) begin
          if (wr) begin
            if (strb[i]) refMem[d][base+i] = data[8*i +: 8];
          end else begin
            e.data[8*i +: 8] = refMem[d][base+i];
          end
        end
      end
      sbq.push_back(e);
    end
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = data;
    pstrb[d]   = strb;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    if (abort) begin
      @(posedge clk); #1;
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("abortReady", 64'(pready[d]), 64'd0);
      return;
    end
    for (int i = 0; i < 40 && !pready[d]; i++) begin
      @(posedge clk); #1;
    end
    if (!pready[d]) failNow("readyTimeout");
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a transfer completes on either DUT.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (psel[d] && !penable[d]) begin
        waitCnt[d] = 0;
      end else if (psel[d] && penable[d] && !pready[d]) begin
        waitCnt[d]++;
      end else if (psel[d] && penable[d] && pready[d]) begin
        if (sbq.size() == 0) begin
          failNow("unexpectedDone");
        end else begin
          e = sbq.pop_front();
          checkOutput("sbDut", 64'(d), 64'(e.dut));
          checkOutput("latency", 64'(waitCnt[d]), 64'(e.waits));
          checkOutput("pslverr", 64'(pslverr[d]), 64'(e.err));
          if (e.isRead || e.err) checkOutput("prdata", 64'(prdata[d]), 64'(e.data));
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; waitCnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rstReady", 64'(pready[d]), 64'd0);
      checkOutput("rstErr", 64'(pslverr[d]), 64'd0);
      checkOutput("rstData", 64'(prdata[d]), 64'd0);
    end
    rst = 1'b0;

    // Give every address used later a defined value.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 32; w++) applyStimulus(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0);
      applyStimulus(d, 1'b1, 32'hFFC, $urandom, 4'hF, 1'b0);
    end

    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      applyStimulus(d, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      applyStimulus(d, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0);
      applyStimulus(d, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
      applyStimulus(d, 1'b0, 32'h1000, 32'h0, 4'hF, 1'b0);
      applyStimulus(d, 1'b1, 32'h13, 32'h55555555, 4'hF, 1'b0);
      applyStimulus(d, 1'b1, 32'h10, 32'h99999999, 4'h0, 1'b0);
      applyStimulus(d, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    end

    applyStimulus(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
    applyStimulus(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);

    // Reset mid-write on the wait-state instance while the other holds read data.
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h14; pwdata[1] = 32'hA5A5A5A5; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("midRstReady", 64'(pready[d]), 64'd0);
      checkOutput("midRstErr", 64'(pslverr[d]), 64'd0);
      checkOutput("midRstData", 64'(prdata[d]), 64'd0);
    end
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0);
    applyStimulus(1, 1'b1, 32'h14, 32'h0BADF00D, 4'hF, 1'b0);
    applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        r = $urandom_range(0, 9);
        if (r <= 6)      a = 32'($urandom_range(0, 31) * 4);
        else if (r == 7) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
        else if (r == 8) a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        else             a = 32'hFFC;
        applyStimulus(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    checkOutput("sbDrained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb4_mem_slave.md
APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, PADDR width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, data width (8, 16, 32 or 64).
REQ-003 Parameter MEM_DEPTH, default 1024, number of DATA_WIDTH words.
REQ-004 Parameter WAIT_STATES, default 0, PREADY-low cycles per access phase (0..15).
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-006 PCLK  input  1  sole clock; all state on rising edge.
REQ-007 PRESET  input  1  asynchronous active-high reset.
REQ-008 PSEL  input  1  slave select.
REQ-009 PENABLE  input  1  access phase marker.
REQ-010 PWRITE  input  1  1 = write, 0 = read.
REQ-011 PADDR  input  ADDR_WIDTH  byte address.
REQ-012 PWDATA  input  DATA_WIDTH  write data.
REQ-013 PSTRB  input  DATA_WIDTH/8  write byte-lane enables.
REQ-014 PRDATA  output  DATA_WIDTH  read data, valid when PREADY=1 and PWRITE=0.
REQ-015 PREADY  output  1  transfer completion.
REQ-016 PSLVERR  output  1  error response, valid only when PREADY=1.

Function
REQ-017 The FSM SHALL have states IDLE and ACCESS (typedef apb4_state_t).
REQ-018 IDLE->ACCESS SHALL occur on an edge with PSEL=1 and PENABLE=0 (setup cycle); all other IDLE cycles hold IDLE.
REQ-019 On the setup edge: wait counter <= WAIT_STATES, word index <= PADDR >> log2(DATA_WIDTH/8), error flag registered, PRDATA <= mem[index] (read, no error) or zero.
REQ-020 The error flag SHALL be set when the word index >= MEM_DEPTH or the PADDR low log2(DATA_WIDTH/8) bits are nonzero.
REQ-021 In ACCESS, PREADY SHALL be 1 exactly when counter==0 (combinational from registers); the counter decrements each ACCESS cycle while nonzero.
REQ-022 PSLVERR SHALL equal the registered error flag while PREADY=1, else 0.
REQ-023 A write SHALL commit on the edge with ACCESS, PREADY=1, PENABLE=1, PWRITE=1 and no error; only bytes with PSTRB[i]=1 are updated.
REQ-024 Write with PSTRB all zero SHALL complete OKAY with memory unchanged.
REQ-025 Errored transfers SHALL leave memory unchanged and return PRDATA=0.
REQ-026 On the completion edge the FSM SHALL go to IDLE; a new setup cycle may follow immediately, giving back-to-back transfers every 2+WAIT_STATES cycles.
REQ-027 PSEL=0 while in ACCESS (master abort) SHALL return to IDLE next edge with no write and PREADY=0.
REQ-028 Total latency, setup cycle to PREADY=1, SHALL be 1+WAIT_STATES cycles.
REQ-029 PSTRB SHALL be ignored for reads.

Reset
REQ-030 While PRESET=1: state=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0.
REQ-031 Reset asserted mid-transfer SHALL abort it with no memory write; memory contents are not cleared.
REQ-032 The first setup cycle SHALL be recognised on the first PCLK edge after PRESET deasserts.

Structure
REQ-033 apb_pkg SHALL hold apb4_state_t and the default-parameter constants.
REQ-034 Storage SHALL be sub-module apb4_mem_array: synchronous read, per-byte write enable, parameters DATA_WIDTH and MEM_DEPTH.

Verification
REQ-035 WAIT_STATES=0: write 0xDEADBEEF to 0x10 with PSTRB=4'hF, then read 0x10 -> PREADY in the first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-036 WAIT_STATES=3: read 0x10 -> PREADY low for 3 access cycles, high on the 4th, data correct.
REQ-037 Write 0x11223344 with PSTRB=4'b0101 over 0xDEADBEEF -> readback 0xDE22BE44.
REQ-038 Read 0x1000 (index 1024) and write to 0x13 (misaligned) -> PSLVERR=1 with PREADY, PRDATA=0, memory unchanged.
REQ-039 Drop PSEL mid-ACCESS during a write to 0x20, then read 0x20 -> prior value, FSM IDLE.
REQ-040 Assert PRESET during a WAIT_STATES=3 write -> outputs zero immediately, location unchanged, next transfer completes normally.
